// File: rtl/cic_i_feeder.sv
// cic_i_feeder: rate-pacing FIFO in front of the CIC interpolator.
// Accepts samples on a valid/ready stream and releases exactly one sample
// strobe every r clocks while running; an empty FIFO at a strobe yields a
// zero sample plus an underflow pulse so the comb cadence never slips.
//
// Handshake: a sample transfers on a clock edge where s_valid && s_ready.
// s_ready depends only on reset_n and the registered level, never on s_valid,
// and it does not anticipate a pop in the same cycle.
module cic_i_feeder #(
    parameter int dw      = 8,
    parameter int r       = 4,
    parameter int depth   = 8,
    parameter int prefill = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [dw-1:0]         s_data,
    output logic                         in_dv,
    output logic signed [dw-1:0]         data_out,
    output logic                         underflow,
    output logic [15:0]                  uf_cnt,
    output logic [$clog2(depth+1)-1:0]   level
);

    localparam int AW = $clog2(depth);
    localparam int LW = $clog2(depth + 1);
    localparam int PW = (r > 1) ? $clog2(r) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_phase;
    logic [PW-1:0]         w_phase_nxt;
    logic signed [dw-1:0]  r_mem [depth];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_in_dv;
    logic signed [dw-1:0]  r_data_out;
    logic                  r_underflow;
    logic [15:0]           r_uf_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_strobe;
    logic                  w_uf;

    assign s_ready   = reset_n && (r_level != LW'(depth));
    assign w_push    = s_valid && s_ready;
    assign in_dv     = r_in_dv;
    assign data_out  = r_data_out;
    assign underflow = r_underflow;
    assign uf_cnt    = r_uf_cnt;
    assign level     = r_level;

    // Next state, phase and strobe decisions from the registered state and level.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_strobe    = 1'b0;
        w_pop       = 1'b0;
        w_uf        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = '0;
                if (en && (r_level >= LW'(prefill))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Leaving RUN: no strobe on this edge, contents kept.
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_strobe    = (r_phase == '0);
                    w_pop       = w_strobe && (r_level != '0);
                    w_uf        = w_strobe && (r_level == '0);
                    w_phase_nxt = (r_phase == PW'(r - 1)) ? '0 : r_phase + PW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // State and phase registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Sample storage; emptiness is tracked by the pointers and level, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointers and occupancy; pointers wrap at depth because depth is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Registered strobe, sample and underflow reporting towards the interpolator.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_dv     <= 1'b0;
            r_data_out  <= '0;
            r_underflow <= 1'b0;
            r_uf_cnt    <= '0;
        end else begin
            r_in_dv     <= w_strobe;
            r_underflow <= w_uf;
            if (w_pop) begin
                r_data_out <= r_mem[r_rd_ptr];
            end else if (w_uf) begin
                // Zero-stuff keeps the comb chain fed with a neutral sample.
                r_data_out <= '0;
            end
            if (w_uf && (r_uf_cnt != 16'hFFFF)) begin
                r_uf_cnt <= r_uf_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/cic_i_feeder.md
# cic_i_feeder

Rate-pacing input buffer placed directly upstream of the CIC interpolator. It accepts samples on a valid/ready stream at an irregular rate and stores them in a small FIFO. It then delivers them to the interpolator as a `data_out`/`in_dv` pair, with exactly one `in_dv` pulse every R clocks, which is the strict cadence the comb chain requires. On underflow it zero-stuffs to keep the cadence intact and reports the event.

## Interface
- `dw`, 8: sample width; equals the interpolator's `dw`.
- `r`, 4: interpolation ratio; `in_dv` period in clocks (`r` ≥ 1).
- `depth`, 8: FIFO depth; power of 2, ≥ 2.
- `prefill`, 4: FIFO level required to leave IDLE; 1 ≤ `prefill` ≤ `depth`.

- `clk`, input, 1: single clock.
- `reset_n`, input, 1: reset; synchronous and active-low.
- `en`, input, 1: run enable.
- `s_valid`, input, 1: upstream sample valid.
- `s_ready`, output, 1: FIFO can accept a sample.
- `s_data`, input, `dw`: upstream sample, signed.
- `in_dv`, output, 1: sample strobe to the interpolator; one-cycle pulse.
- `data_out`, output, `dw`: sample to the interpolator, signed; meaningful when `in_dv` = 1.
- `underflow`, output, 1: one-cycle pulse; a strobe found the FIFO empty.
- `uf_cnt`, output, 16: saturating underflow count.
- `level`, output, `$clog2(depth+1)`: current FIFO occupancy.

## Operation
- **Push:** a write occurs on a clock where `s_valid` && `s_ready`.
  - `s_ready` = `reset_n` && (`level` != `depth`). It is combinational from the registered level.
  - There is no pop-bypass: when the FIFO is full, `s_ready` = 0 even if a pop happens in the same cycle.
- **FIFO:** circular RAM with read and write pointers of width `$clog2(depth)`, which wrap naturally.
  - `level` is a registered counter: +1 on push only, −1 on pop only, unchanged on push and pop together.
- **State IDLE:**
  - `phase` = 0, no strobes, `in_dv` = 0.
  - Transition to RUN at a clock edge where `en` = 1 and `level` ≥ `prefill`. The push in that cycle is not counted.
- **State RUN:**
  - `phase` counts 0 … `r`−1 and wraps.
  - A strobe cycle is any cycle in RUN with `phase` = 0:
    - FIFO not empty: pop, `data_out` ← head, `in_dv` ← 1.
    - FIFO empty: `data_out` ← 0, `in_dv` ← 1, `underflow` ← 1, `uf_cnt` ← min(`uf_cnt`+1, 65535).
  - Non-strobe cycles: `in_dv` ← 0, `underflow` ← 0, `data_out` holds its value.
  - Transition to IDLE at any edge where `en` = 0. On that edge: `phase` ← 0, `in_dv` ← 0, no pop. FIFO contents are retained.
  - Re-entering RUN requires the prefill condition again.
- **Simultaneous push to an empty FIFO and strobe:** the strobe sees the FIFO empty, so an underflow occurs. The pushed sample is kept for the next strobe.
- **`r` = 1:** `phase` stays 0, so a strobe occurs on every RUN cycle.
- Data passes through unmodified: no rounding and no sign change.

## Timing
- **Reset** (`reset_n` = 0 at an edge): FIFO emptied, `level` = 0, state IDLE, `phase` = 0, `in_dv` = 0, `data_out` = 0, `underflow` = 0, `uf_cnt` = 0.
  - `s_ready` = 0 while `reset_n` = 0, and 1 once it is released.
  - Reset applied mid-operation discards all buffered samples.
- Edge E0 takes the state to RUN. The first `in_dv` is high in the cycle following edge E0+1. Every later `in_dv` follows the previous one by exactly `r` clocks.
- `in_dv`, `data_out` and `underflow` are registered. `in_dv` and `underflow` are high together for one cycle.
- Minimum latency from push to `in_dv` for that sample: 2 clocks plus the wait for the next `phase` = 0.
- The sustainable input rate is 1 sample per `r` clocks. A faster input fills the FIFO and is throttled by `s_ready`.

## Test plan
- **Reset:** assert `reset_n` = 0 with `s_valid` = 1.
  - During reset: `s_ready` = 0.
  - After release: `level` = 0, `in_dv` = 0, `data_out` = 0, `uf_cnt` = 0, `s_ready` = 1.
- **Prefill and underflow** (`r`=4, `depth`=8, `prefill`=4, `en`=1): push 1, 2, 3, 4 back-to-back.
  - Expect RUN entry, then `in_dv` pulses 4 clocks apart carrying 1, 2, 3, 4.
  - Pulses 5 and 6 carry `data_out` = 0 with `underflow` = 1; `uf_cnt` = 2.
- **Full:** `en` = 0, push 10 samples continuously.
  - Exactly 8 are accepted, then `s_ready` = 0 and `level` = 8.
  - No `in_dv` occurs.
- **Sustained rate:** after prefill, push −128, 127, −1, … one sample every 4 clocks for 1000 strobes.
  - Zero underflows, `level` stays constant, output sequence equals input sequence (signed values intact).
- **Enable drop:** `en` → 0 in the middle of RUN with `level` = 3.
  - `in_dv` never fires after that edge and `level` stays 3.
  - `en` → 1: no strobe until `level` ≥ 4, then cadence restarts with the first `in_dv` at E0+2.
- **Mid-run reset and `r` = 1:**
  - Reset with `level` = 5: all outputs and `level` go to 0.
  - With `r` = 1 and `prefill` = 1: `in_dv` is high on every RUN cycle while data is available.
